alu16_serial_sub: RTL and testbench

//   Multi-cycle 16-bit subtractor for the ALU16 datapath: computes a - b - bin, one nibble per cycle, LSB first.
//   It is the counterpart to the ripple adder and needs only a 4-bit borrow chain in logic, not 16 bits.

---
 rtl/alu16_serial_sub_pkg.sv | 22 ++
 rtl/alu16_serial_sub_nibble.sv | 32 +++
 rtl/alu16_serial_sub.sv | 117 +++++++++++
 tb/tb_alu16_serial_sub.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu16_serial_sub_pkg.sv
// Shared definitions for the ALU16 nibble-serial subtractor.
// Holds the default datapath geometry, the FSM state encodings and a small
// helper for the signed-overflow rule so the top level reads cleanly.
package alu16_serial_sub_pkg;

  localparam int ALU16_WIDTH = 16;
  localparam int ALU16_DIGIT = 4;

  // Encoding 2'd3 is unused; the FSM steers it back to idle.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Subtraction overflows only when the operands have different signs and
  // the result sign differs from the minuend sign.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu16_serial_sub_nibble.sv
// sub_nibble: combinational DIGIT-bit borrow-ripple subtractor.
// Ports:
//   x  in  DIGIT  minuend digit
//   y  in  DIGIT  subtrahend digit
//   bi in  1      borrow in
//   d  out DIGIT  difference digit x - y - bi
//   bo out 1      borrow out (1 iff x < y + bi)
module sub_nibble #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic chain;

  // Full-subtractor per bit; a borrow propagates when x is 0 and either y or
  // the incoming borrow is set, or when both y and the incoming borrow are set.
  always_comb begin
    d     = '0;
    chain = bi;
    for (int k = 0; k < DIGIT; k++) begin
      d[k]  = x[k] ^ y[k] ^ chain;
      chain = (~x[k] & (y[k] | chain)) | (y[k] & chain);
    end
    bo = chain;
  end

endmodule

// File: rtl/alu16_serial_sub.sv
// alu16_serial_sub: multi-cycle subtractor computing a - b - bin one digit
// per cycle, least significant digit first, with a start/busy/done handshake.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset
//   start in  1      request, honoured only in IDLE or DONE
//   a     in  WIDTH  minuend, captured on an accepted start
//   b     in  WIDTH  subtrahend, captured on an accepted start
//   bin   in  1      borrow in, captured on an accepted start
//   busy  out 1      high while digits are being processed
//   done  out 1      one-cycle pulse when the result registers are fresh
//   diff  out WIDTH  a - b - bin modulo 2^WIDTH
//   bout  out 1      unsigned borrow out
//   ovf   out 1      signed overflow
//   zero  out 1      diff is all zeros
import alu16_serial_sub_pkg::*;

module alu16_serial_sub #(
  parameter int WIDTH = ALU16_WIDTH,
  parameter int DIGIT = ALU16_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  part;
  logic [WIDTH-1:0]  final_part;
  logic              borrow;
  logic [DIGIT-1:0]  nib_d;
  logic              nib_bo;

  // One shared digit subtractor; the step counter selects which digit of the
  // captured operands it sees this cycle.
  sub_nibble #(.DIGIT(DIGIT)) u_sub_nibble (
    .x  (a_r[int'(step)*DIGIT +: DIGIT]),
    .y  (b_r[int'(step)*DIGIT +: DIGIT]),
    .bi (borrow),
    .d  (nib_d),
    .bo (nib_bo)
  );

  // Partial result with the current digit merged in; on the last step this
  // is the complete difference, so flags can be registered in the same edge.
  always_comb begin
    final_part = part;
    final_part[int'(step)*DIGIT +: DIGIT] = nib_d;
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Result registers are only written when entering DONE so they hold across
  // idle periods and the whole of the following operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      step   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      part   <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            part   <= '0;
            step   <= '0;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          part   <= final_part;
          borrow <= nib_bo;
          if (step == LAST_STEP) begin
            diff  <= final_part;
            bout  <= nib_bo;
            ovf   <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], final_part[WIDTH-1]);
            zero  <= (final_part == '0);
            step  <= '0;
            state <= S_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_serial_sub.sv
// Testbench for alu16_serial_sub: directed spec vectors, handshake and reset
// scenarios, then randomized operations compared against an arithmetic model.
module tb_alu16_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;

  // Result currently expected on the outputs: {bout, ovf, zero, diff}.
  logic [18:0] exp_res;

  alu16_serial_sub dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Plain integer arithmetic reference for a - b - bin.
  function automatic logic [18:0] model(input logic [15:0] ma,
                                        input logic [15:0] mb,
                                        input logic        mbin);
    int          ud;
    int          sd;
    logic [15:0] d;
    ud = int'(ma) - int'(mb) - int'(mbin);
    sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    d  = ud[15:0];
    return {ud < 0, (sd < -32768) || (sd > 32767), d == 16'h0000, d};
  endfunction

  function automatic logic [18:0] res_word();
    return {bout, ovf, zero, diff};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the start is sampled on the next rising edge E.
  // Checks busy/done/held outputs for E+1..E+4 and the result in E+5, and
  // returns still inside the done cycle so the caller can chain another op.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tbin, input bit hold,
                               input string tag);
    logic [18:0] want;
    want  = model(ta, tb_, tbin);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " done early"}, 32'(done), 32'd0);
      checkOutput({tag, " held result"}, 32'(res_word()), 32'(exp_res));
      if (hold) begin
        a     = 16'($urandom);
        b     = 16'($urandom);
        bin   = 1'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy off"}, 32'(busy), 32'd0);
    checkOutput({tag, " result"}, 32'(res_word()), 32'(want));
    exp_res = want;
    start   = 1'b0;
  endtask

  task automatic idleCycles(input int n, input string tag);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput({tag, " idle done"}, 32'(done), 32'd0);
      checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " idle held"}, 32'(res_word()), 32'(exp_res));
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bin     = 1'b0;
    exp_res = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(res_word()), 32'd0);
    rst = 1'b0;
    idleCycles(2, "post-reset");

    applyStimulus(16'h0005, 16'h0003, 1'b0, 1'b0, "basic");
    checkOutput("basic diff", 32'(diff), 32'h0002);
    idleCycles(1, "basic");

    applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0, "ubrw");
    checkOutput("ubrw flags", 32'({bout, ovf, zero, diff}), 32'({1'b1, 1'b0, 1'b0, 16'hFFFF}));
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0, "ovf1");
    checkOutput("ovf1 flags", 32'({bout, ovf, zero, diff}), 32'({1'b0, 1'b1, 1'b0, 16'h7FFF}));
    applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, "ovf2");
    checkOutput("ovf2 flags", 32'({bout, ovf, zero, diff}), 32'({1'b1, 1'b1, 1'b0, 16'h8000}));
    applyStimulus(16'h1234, 16'h1233, 1'b1, 1'b0, "bin-zero");
    checkOutput("bin-zero flags", 32'({bout, ovf, zero, diff}), 32'({1'b0, 1'b0, 1'b1, 16'h0000}));
    applyStimulus(16'h1000, 16'h0001, 1'b0, 1'b0, "xnib");
    checkOutput("xnib diff", 32'(diff), 32'h0FFF);
    idleCycles(2, "xnib");

    // Start held through RUN with changing operands, then back-to-back start.
    applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b1, "hold");
    checkOutput("hold diff", 32'(diff), 32'h3210);
    applyStimulus(16'h00FF, 16'h000F, 1'b0, 1'b0, "b2b");
    checkOutput("b2b diff", 32'(diff), 32'h00F0);
    idleCycles(1, "b2b");

    // Reset sampled at E+2 of an operation discards it.
    a     = 16'h9999;
    b     = 16'h1111;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst result", 32'(res_word()), 32'd0);
    rst     = 1'b0;
    exp_res = '0;
    idleCycles(6, "midrst");
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "after-rst");
    checkOutput("after-rst zero", 32'({zero, diff}), 32'({1'b1, 16'h0000}));

    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idleCycles(gap, "rand");
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom),
                    1'($urandom), "rand");
    end
    idleCycles(2, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
